// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus opcodes, default widths and address decode
package bus_pkg;

    localparam logic BUS_OP_WR  = 1'b1;
    localparam logic BUS_OP_RD  = 1'b0;
    localparam int   BUS_ADDR_W = 16;
    localparam int   BUS_DATA_W = 16;

    // Inputs are zero-extended; the >= test keeps addresses below base from wrapping into a hit.
    function automatic logic addr_hit(input logic [63:0] addr, input logic [63:0] base,
                                      input logic [63:0] num);
        return (addr >= base) && ((addr - base) < num);
    endfunction

endpackage

// File: rtl/bus_rd_pipe.sv
// rtl/bus_rd_pipe.sv - fixed-latency valid/data/err delay line for bus reads
module bus_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] err_q;
    logic [DATA_W-1:0] data_q [RD_LAT];

    // Data stages only load behind a valid, so the last stage holds the previous read result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
        end else begin
            vld_q[0] <= in_vld;
            err_q[0] <= in_err;
            if (in_vld) data_q[0] <= in_data;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                if (vld_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_vld  = vld_q[RD_LAT-1];
    assign out_err  = err_q[RD_LAT-1];
    assign out_data = data_q[RD_LAT-1];

endmodule

// File: rtl/bus_regfile_slave.sv
// rtl/bus_regfile_slave.sv - parametrised CPU-bus register file with hardware write port
module bus_regfile_slave
    import bus_pkg::*;
#(
    parameter int                  ADDR_W    = BUS_ADDR_W,
    parameter int                  DATA_W    = BUS_DATA_W,
    parameter int                  NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
    parameter int                  RD_LAT    = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         bus_cs,
    input  logic                         bus_op,
    input  logic [ADDR_W-1:0]            bus_addr,
    input  logic [DATA_W-1:0]            bus_wr_data,
    output logic [DATA_W-1:0]            bus_rd_data,
    output logic                         bus_rd_vld,
    output logic                         bus_err,
    input  logic [NUM_REGS-1:0]          hw_wr_en,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_wr_data,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          reg_wr_pulse
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                hit;
    logic [IDX_W-1:0]    idx;
    logic                rd_req;
    logic                wr_req;
    logic                wr_ok;
    logic [NUM_REGS-1:0] wr_sel;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   rd_word;
    logic                wr_err_q;
    logic                rd_err;

    assign hit    = addr_hit(64'(bus_addr), 64'(BASE_ADDR), 64'(NUM_REGS));
    assign idx    = IDX_W'(bus_addr - BASE_ADDR);
    assign rd_req = bus_cs && (bus_op == BUS_OP_RD);
    assign wr_req = bus_cs && (bus_op == BUS_OP_WR);
    assign wr_ok  = wr_req && hit && !RO_MASK[idx];

    always_comb begin
        wr_sel = '0;
        if (wr_ok) wr_sel[idx] = 1'b1;
    end

    // Read data is taken from the pre-edge contents, so same-edge writes are not visible.
    assign rd_word = hit ? regs[idx] : '0;

    // Bus write outranks the hardware port on the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i])
                    regs[i] <= bus_wr_data;
                else if (hw_wr_en[i])
                    regs[i] <= hw_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wr_pulse <= '0;
            wr_err_q     <= 1'b0;
        end else begin
            reg_wr_pulse <= wr_sel;
            wr_err_q     <= wr_req && !wr_ok;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
        assign reg_q[i*DATA_W +: DATA_W] = regs[i];
    end

    bus_rd_pipe #(
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rd_req),
        .in_data (rd_word),
        .in_err  (rd_req && !hit),
        .out_vld (bus_rd_vld),
        .out_data(bus_rd_data),
        .out_err (rd_err)
    );

    assign bus_err = wr_err_q | rd_err;

endmodule

// File: tb/tb_bus_regfile_slave.sv
// tb/tb_bus_regfile_slave.sv - three-configuration bench for bus_regfile_slave
module tb_bus_regfile_slave;

    localparam int NG = 3;
    localparam int NR = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              bus_cs = 1'b0;
    logic              bus_op = 1'b0;
    logic [15:0]       bus_addr = '0;
    logic [DW-1:0]     bus_wr_data = '0;
    logic [NR-1:0]     hw_wr_en = '0;
    logic [NR*DW-1:0]  hw_wr_data = '0;

    logic [DW-1:0]     rd_data [NG];
    logic              rd_vld [NG];
    logic              err [NG];
    logic [NR*DW-1:0]  reg_q [NG];
    logic [NR-1:0]     wr_pulse [NG];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_regfile_slave #(.RD_LAT(1), .RO_MASK(16'h0001)) u0 (
        .clk(clk), .rst_n(rst_n), .bus_cs(bus_cs), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_rd_data(rd_data[0]), .bus_rd_vld(rd_vld[0]),
        .bus_err(err[0]), .hw_wr_en(hw_wr_en), .hw_wr_data(hw_wr_data),
        .reg_q(reg_q[0]), .reg_wr_pulse(wr_pulse[0]));

    bus_regfile_slave #(.RD_LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .bus_cs(bus_cs), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_rd_data(rd_data[1]), .bus_rd_vld(rd_vld[1]),
        .bus_err(err[1]), .hw_wr_en(hw_wr_en), .hw_wr_data(hw_wr_data),
        .reg_q(reg_q[1]), .reg_wr_pulse(wr_pulse[1]));

    bus_regfile_slave #(.RD_LAT(4), .BASE_ADDR(16'h0100)) u2 (
        .clk(clk), .rst_n(rst_n), .bus_cs(bus_cs), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_rd_data(rd_data[2]), .bus_rd_vld(rd_vld[2]),
        .bus_err(err[2]), .hw_wr_en(hw_wr_en), .hw_wr_data(hw_wr_data),
        .reg_q(reg_q[2]), .reg_wr_pulse(wr_pulse[2]));

    function automatic int lat_of(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int base_of(input int g);
        return (g == 2) ? 32'h0100 : 0;
    endfunction

    function automatic logic [NR-1:0] ro_of(input int g);
        return (g == 0) ? 16'h0001 : 16'h0000;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: register array plus a timeline of expected output events, indexed by cycle mod 8.
    logic [DW-1:0] m_regs  [NG][NR];
    logic          m_vld   [NG][8];
    logic [DW-1:0] m_data  [NG][8];
    logic          m_err   [NG][8];
    logic [NR-1:0] m_pulse [NG][8];
    logic [DW-1:0] m_last  [NG];
    int            k = 0;

    function automatic logic [NR*DW-1:0] model_q(input int g);
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[g][i];
        return v;
    endfunction

    task automatic model_clear();
        for (int g = 0; g < NG; g++) begin
            for (int i = 0; i < NR; i++) m_regs[g][i] = '0;
            for (int s = 0; s < 8; s++) begin
                m_vld[g][s] = 1'b0; m_data[g][s] = '0; m_err[g][s] = 1'b0; m_pulse[g][s] = '0;
            end
            m_last[g] = '0;
        end
    endtask

    // Apply the inputs the DUT will sample at the coming posedge.
    task automatic model_advance();
        int off;
        bit hit;
        logic [NR-1:0] ro;
        for (int g = 0; g < NG; g++) begin
            off = int'(bus_addr) - base_of(g);
            hit = (off >= 0) && (off < NR);
            ro  = ro_of(g);
            if (bus_cs && !bus_op) begin
                m_vld[g][(k + lat_of(g)) % 8] = 1'b1;
                if (hit) m_data[g][(k + lat_of(g)) % 8] = m_regs[g][off];
                else begin
                    m_data[g][(k + lat_of(g)) % 8] = '0;
                    m_err[g][(k + lat_of(g)) % 8]  = 1'b1;
                end
            end
            for (int i = 0; i < NR; i++)
                if (hw_wr_en[i]) m_regs[g][i] = hw_wr_data[i*DW +: DW];
            if (bus_cs && bus_op) begin
                if (hit && !ro[off]) begin
                    m_regs[g][off] = bus_wr_data;
                    m_pulse[g][(k + 1) % 8][off] = 1'b1;
                end else begin
                    m_err[g][(k + 1) % 8] = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        int s;
        logic [DW-1:0] exp_data;
        if (!rst_n) model_clear();
        s = k % 8;
        for (int g = 0; g < NG; g++) begin
            exp_data = m_vld[g][s] ? m_data[g][s] : m_last[g];
            check($sformatf("u%0d.rd_vld cyc%0d", g, k), rd_vld[g], m_vld[g][s]);
            check($sformatf("u%0d.rd_data cyc%0d", g, k), rd_data[g], exp_data);
            check($sformatf("u%0d.bus_err cyc%0d", g, k), err[g], m_err[g][s]);
            check($sformatf("u%0d.reg_wr_pulse cyc%0d", g, k), wr_pulse[g], m_pulse[g][s]);
            check($sformatf("u%0d.reg_q cyc%0d", g, k), reg_q[g], model_q(g));
            m_last[g]  = exp_data;
            m_vld[g][s] = 1'b0; m_data[g][s] = '0; m_err[g][s] = 1'b0; m_pulse[g][s] = '0;
        end
        if (rst_n) model_advance();
        k++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus_cs = 1'b0; bus_op = 1'b0; hw_wr_en = '0;
    endtask

    task automatic bus_req(input logic op, input logic [15:0] a, input logic [15:0] d);
        bus_cs = 1'b1; bus_op = op; bus_addr = a; bus_wr_data = d;
    endtask

    task automatic hw_wr(input int i, input logic [15:0] d);
        hw_wr_en[i] = 1'b1;
        hw_wr_data[i*DW +: DW] = d;
    endtask

    initial begin
        int cnt;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset reg_q", reg_q[0], '0);
        check("reset rd_vld", rd_vld[0], 1'b0);

        bus_req(1'b1, 16'd3, 16'h00A5); tick();
        check("t1 pulse", wr_pulse[0], 16'h0008);
        check("t1 err", err[0], 1'b0);
        check("t1 reg3", reg_q[0][3*DW +: DW], 16'h00A5);
        bus_req(1'b0, 16'd3, 16'h0000); tick();
        check("t1 rd_vld", rd_vld[0], 1'b1);
        check("t1 rd_data", rd_data[0], 16'h00A5);
        check("t1 pulse once", wr_pulse[0], 16'h0000);
        idle(); tick();
        check("t1 rd_vld drop", rd_vld[0], 1'b0);

        bus_req(1'b1, 16'd0, 16'hFFFF); tick();
        check("t2 ro err", err[0], 1'b1);
        check("t2 ro pulse", wr_pulse[0], 16'h0000);
        check("t2 ro reg0", reg_q[0][0 +: DW], 16'h0000);
        idle(); hw_wr(0, 16'h1234); tick();
        check("t2 err clear", err[0], 1'b0);
        idle(); bus_req(1'b0, 16'd0, 16'h0000); tick();
        check("t2 hw rd_data", rd_data[0], 16'h1234);

        bus_req(1'b1, 16'd1, 16'd1); tick();
        bus_req(1'b1, 16'd2, 16'd2); tick();
        bus_req(1'b1, 16'd5, 16'd5); tick();
        bus_req(1'b0, 16'd1, 16'd0); tick();
        check("t3 early vld a", rd_vld[1], 1'b0);
        bus_req(1'b0, 16'd2, 16'd0); tick();
        check("t3 early vld b", rd_vld[1], 1'b0);
        bus_req(1'b0, 16'd5, 16'd0); tick();
        check("t3 vld0", rd_vld[1], 1'b1);
        check("t3 data0", rd_data[1], 16'd1);
        idle(); tick();
        check("t3 data1", rd_data[1], 16'd2);
        tick();
        check("t3 data2", rd_data[1], 16'd5);
        tick();
        check("t3 vld end", rd_vld[1], 1'b0);
        check("t3 hold", rd_data[1], 16'd5);

        bus_req(1'b0, 16'd16, 16'd0); tick();
        check("t4 miss vld", rd_vld[0], 1'b1);
        check("t4 miss data", rd_data[0], 16'h0000);
        check("t4 miss err", err[0], 1'b1);
        bus_req(1'b0, 16'h00FF, 16'd0); tick();
        idle(); repeat (3) tick();
        check("t4 base miss vld", rd_vld[2], 1'b1);
        check("t4 base miss err", err[2], 1'b1);

        bus_req(1'b1, 16'd4, 16'h0011); hw_wr(4, 16'h0022); tick();
        check("t5 bus wins", reg_q[0][4*DW +: DW], 16'h0011);
        check("t5 pulse", wr_pulse[0], 16'h0010);
        idle(); bus_req(1'b0, 16'd4, 16'd0); hw_wr(4, 16'h0033); tick();
        check("t5 old value", rd_data[0], 16'h0011);
        check("t5 hw landed", reg_q[0][4*DW +: DW], 16'h0033);

        idle(); bus_req(1'b1, 16'h0103, 16'h0BEE); tick();
        check("t6 reg3", reg_q[2][3*DW +: DW], 16'h0BEE);
        bus_req(1'b0, 16'h0103, 16'd0); tick();
        idle(); repeat (3) tick();
        check("t6 pre rd", rd_data[2], 16'h0BEE);
        bus_req(1'b0, 16'h0103, 16'd0); tick();
        idle(); tick();
        rst_n = 1'b0;
        #1;
        check("t6 rst vld", rd_vld[2], 1'b0);
        check("t6 rst data", rd_data[2], 16'h0000);
        check("t6 rst reg_q", reg_q[2], '0);
        tick(); tick();
        rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            tick();
            if (rd_vld[2]) cnt++;
        end
        check("t6 no vld", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
